// File: rtl/icap_reg_access.sv
// ICAPE2 sequencer: sync-wrapped single-word Type-1 write/read; `ICAP_IPROG_EN adds op 10 (WBSTAR + IPROG).
// Latency: first word 1 cycle after accept, resp_valid 12 cycles (write) / 16+READ_WAIT cycles (read) after accept.
// Backpressure: req_ready high only in IDLE; requests while busy are dropped, responses cannot be stalled.
module icap_reg_access #(
  parameter int unsigned READ_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o
);

  localparam logic [1:0]  OP_WR       = 2'b00;
  localparam logic [1:0]  OP_RD       = 2'b01;
`ifdef ICAP_IPROG_EN
  localparam logic [1:0]  OP_IPROG    = 2'b10;
  localparam logic [31:0] WBSTAR_HDR  = 32'h30020001;
  localparam logic [31:0] IPROG_CMD   = 32'h0000000F;
`endif
  localparam logic [31:0] WR_HDR_BASE = 32'h30000001;
  localparam logic [31:0] RD_HDR_BASE = 32'h28000001;
  localparam logic [31:0] CMD_HDR     = 32'h30008001;
  localparam logic [31:0] DESYNC_CMD  = 32'h0000000D;
  localparam logic [31:0] DUMMY       = 32'hFFFFFFFF;
  localparam logic [31:0] SYNC_WORD   = 32'hAA995566;
  localparam logic [31:0] NOOP        = 32'h20000000;
  localparam logic [3:0]  RW_LAST     = 4'(READ_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_WR_BODY, S_RD_HDR, S_TURN_A, S_TURN_B,
    S_RD_WAIT, S_TURN_C, S_TURN_D, S_DESYNC, S_RESP
`ifdef ICAP_IPROG_EN
    , S_IPROG, S_IPROG_DONE
`endif
  } state_t;

  state_t      state, nxt_state;
  logic [3:0]  cnt, nxt_cnt;
  logic [1:0]  op_q;
  logic [4:0]  addr_q;
  logic [31:0] wdata_q, rdata_q, nxt_word;
  logic        csib_nxt, rdwrb_nxt, accept;

  // ICAP expects each byte bit-reversed relative to the bitstream word.
  function automatic logic [31:0] bit_swap(input logic [31:0] v);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++)
        r[8*k+j] = v[8*k+7-j];
    return r;
  endfunction

  assign accept = (state == S_IDLE) && req_valid;

  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE: if (req_valid) begin
        case (req_op)
          OP_WR, OP_RD: nxt_state = S_SYNC;
`ifdef ICAP_IPROG_EN
          OP_IPROG:     nxt_state = S_IPROG;
`endif
          default:      nxt_state = S_RESP;
        endcase
      end
      S_SYNC:    if (cnt == 4'd3) nxt_state = (op_q == OP_RD) ? S_RD_HDR : S_WR_BODY;
      S_WR_BODY: if (cnt == 4'd2) nxt_state = S_DESYNC;
      S_RD_HDR:  if (cnt == 4'd2) nxt_state = S_TURN_A;
      S_TURN_A:  nxt_state = S_TURN_B;
      S_TURN_B:  nxt_state = S_RD_WAIT;
      S_RD_WAIT: if (cnt == RW_LAST) nxt_state = S_TURN_C;
      S_TURN_C:  nxt_state = S_TURN_D;
      S_TURN_D:  nxt_state = S_DESYNC;
      S_DESYNC:  if (cnt == 4'd3) nxt_state = S_RESP;
`ifdef ICAP_IPROG_EN
      S_IPROG:      if (cnt == 4'd7) nxt_state = S_IPROG_DONE;
      S_IPROG_DONE: nxt_state = S_IPROG_DONE;
`endif
      default:   nxt_state = S_IDLE;
    endcase
    nxt_cnt = (nxt_state == state) ? cnt + 4'd1 : 4'd0;

    // Word to present next cycle; wdata/addr are already latched whenever they are needed.
    nxt_word = DUMMY;
    case (nxt_state)
      S_SYNC: case (nxt_cnt)
        4'd0:    nxt_word = DUMMY;
        4'd1:    nxt_word = SYNC_WORD;
        default: nxt_word = NOOP;
      endcase
      S_WR_BODY: case (nxt_cnt)
        4'd0:    nxt_word = WR_HDR_BASE | {14'd0, addr_q, 13'd0};
        4'd1:    nxt_word = wdata_q;
        default: nxt_word = NOOP;
      endcase
      S_RD_HDR:  nxt_word = (nxt_cnt == 4'd0) ? (RD_HDR_BASE | {14'd0, addr_q, 13'd0}) : NOOP;
      S_DESYNC: case (nxt_cnt)
        4'd0:    nxt_word = CMD_HDR;
        4'd1:    nxt_word = DESYNC_CMD;
        default: nxt_word = NOOP;
      endcase
`ifdef ICAP_IPROG_EN
      S_IPROG: case (nxt_cnt)
        4'd0:    nxt_word = DUMMY;
        4'd1:    nxt_word = SYNC_WORD;
        4'd3:    nxt_word = WBSTAR_HDR;
        4'd4:    nxt_word = wdata_q;
        4'd5:    nxt_word = CMD_HDR;
        4'd6:    nxt_word = IPROG_CMD;
        default: nxt_word = NOOP;
      endcase
`endif
      default:   nxt_word = DUMMY;
    endcase

    csib_nxt = 1'b1;
    case (nxt_state)
      S_SYNC, S_WR_BODY, S_RD_HDR, S_RD_WAIT, S_DESYNC: csib_nxt = 1'b0;
`ifdef ICAP_IPROG_EN
      S_IPROG: csib_nxt = 1'b0;
`endif
      default: csib_nxt = 1'b1;
    endcase
    rdwrb_nxt = (nxt_state == S_TURN_B) || (nxt_state == S_RD_WAIT) || (nxt_state == S_TURN_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      op_q       <= 2'b00;
      addr_q     <= 5'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b0;
      icap_i     <= DUMMY;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == S_RD_WAIT && cnt == RW_LAST)
        rdata_q <= bit_swap(icap_o);
      icap_csib  <= csib_nxt;
      icap_rdwrb <= rdwrb_nxt;
      icap_i     <= bit_swap(nxt_word);
      req_ready  <= (nxt_state == S_IDLE);
      resp_valid <= (nxt_state == S_RESP);
      // RESP straight from IDLE only happens for a rejected op.
      resp_err   <= (nxt_state == S_RESP) && (state == S_IDLE);
      resp_rdata <= (nxt_state == S_RESP && state == S_DESYNC && op_q == OP_RD) ? rdata_q : 32'd0;
    end
  end

endmodule

// File: tb/tb_icap_reg_access.sv
// Bench for icap_reg_access: per-cycle trace model built from the word lists, plus literal spot checks.
module tb_icap_reg_access;
  localparam int RW = 4;
  localparam logic [31:0] NOOP = 32'h20000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [4:0]  req_addr = 5'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        icap_csib, icap_rdwrb;
  logic [31:0] icap_i;
  logic [31:0] icap_o = 32'd0;

  always #5 clk = ~clk;

  icap_reg_access #(.READ_WAIT(RW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i), .icap_o(icap_o)
  );

  typedef struct packed {
    logic csib; logic rdwrb; logic ready; logic vld; logic err;
    logic [31:0] word; logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  bit          dead = 0, cur_rst = 0, model_valid = 0;
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  int          rd_cyc = 0, rd_low = 0, n_resp = 0;
  logic [31:0] rd_val = 32'h12345678;
  logic [31:0] wlog[$];
  logic        prev_csib = 1'b1, prev_rdwrb = 1'b0;

  function automatic logic [31:0] bswap(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = v[(b & ~7) + (7 - (b & 7))];
    return r;
  endfunction

  function automatic exp_t wd(input logic [31:0] v);
    exp_t e; e = '0; e.word = v; return e;
  endfunction
  function automatic exp_t pins(input logic c, input logic r);
    exp_t e; e = '0; e.csib = c; e.rdwrb = r; e.word = 32'hFFFFFFFF; return e;
  endfunction
  function automatic exp_t resp(input logic err, input logic [31:0] d);
    exp_t e; e = pins(1'b1, 1'b0); e.vld = 1'b1; e.err = err; e.rdata = d; return e;
  endfunction
  function automatic exp_t idle_e();
    exp_t e; e = pins(1'b1, 1'b0); e.ready = 1'b1; return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_sync();
    q.push_back(wd(32'hFFFFFFFF)); q.push_back(wd(32'hAA995566));
    q.push_back(wd(NOOP)); q.push_back(wd(NOOP));
  endtask
  task automatic push_desync();
    q.push_back(wd(32'h30008001)); q.push_back(wd(32'h0000000D));
    q.push_back(wd(NOOP)); q.push_back(wd(NOOP));
  endtask

  // Expected pin/response trace, one entry per cycle following acceptance.
  task automatic build(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    case (op)
      2'b00: begin
        push_sync();
        q.push_back(wd(32'h30000001 | (32'(a) << 13))); q.push_back(wd(d)); q.push_back(wd(NOOP));
        push_desync();
        q.push_back(resp(1'b0, 32'd0));
      end
      2'b01: begin
        push_sync();
        q.push_back(wd(32'h28000001 | (32'(a) << 13))); q.push_back(wd(NOOP)); q.push_back(wd(NOOP));
        q.push_back(pins(1'b1, 1'b0)); q.push_back(pins(1'b1, 1'b1));
        for (int i = 0; i < RW; i++) q.push_back(pins(1'b0, 1'b1));
        q.push_back(pins(1'b1, 1'b1)); q.push_back(pins(1'b1, 1'b0));
        push_desync();
        q.push_back(resp(1'b0, rd_val));
      end
`ifdef ICAP_IPROG_EN
      2'b10: begin
        q.push_back(wd(32'hFFFFFFFF)); q.push_back(wd(32'hAA995566)); q.push_back(wd(NOOP));
        q.push_back(wd(32'h30020001)); q.push_back(wd(d)); q.push_back(wd(32'h30008001));
        q.push_back(wd(32'h0000000F)); q.push_back(wd(NOOP));
        dead = 1;
      end
`endif
      default: q.push_back(resp(1'b1, 32'd0));
    endcase
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete(); dead = 0; cur = idle_e(); cur_rst = 1;
    end else begin
      cur_rst = 0;
      if (cur.ready && req_valid) build(req_op, req_addr, req_wdata);
      if (q.size() > 0) cur = q.pop_front();
      else if (dead) cur = pins(1'b1, 1'b0);
      else cur = idle_e();
    end
    model_valid = 1;
  end

  // Per-cycle compare plus the ICAP readback responder.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("csib", 32'(icap_csib), 32'(cur.csib));
      chk("rdwrb", 32'(icap_rdwrb), 32'(cur.rdwrb));
      chk("req_ready", 32'(req_ready), 32'(cur.ready));
      chk("resp_valid", 32'(resp_valid), 32'(cur.vld));
      chk("resp_err", 32'(resp_err), 32'(cur.err));
      if (!cur.csib && !cur.rdwrb) chk("icap_i", icap_i, bswap(cur.word));
      if (cur.vld) chk("resp_rdata", resp_rdata, cur.rdata);
      if (!cur_rst && icap_rdwrb !== prev_rdwrb)
        chk("rdwrb_change_csib_high", {30'd0, icap_csib, prev_csib}, 32'd3);
    end
    if (icap_csib === 1'b0 && icap_rdwrb === 1'b0) wlog.push_back(bswap(icap_i));
    if (resp_valid === 1'b1) n_resp++;
    if (icap_csib === 1'b0 && icap_rdwrb === 1'b1) begin
      rd_cyc++; rd_low++;
    end else rd_cyc = 0;
    icap_o = (rd_cyc == RW) ? bswap(rd_val) : (32'hBAD00000 | 32'(rd_cyc));
    prev_csib = icap_csib; prev_rdwrb = icap_rdwrb;
  end

  task automatic do_req(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d,
                        output logic got_err, output logic [31:0] got_rd);
    bit seen;
    seen = 0; got_err = 1'bx; got_rd = 'x;
    req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (resp_valid === 1'b1) begin
        seen = 1; got_err = resp_err; got_rd = resp_rdata; break;
      end
      @(negedge clk);
    end
    chk("resp_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        e;
    logic [31:0] rd;
    logic [31:0] lit1 [11];
    bit          found;
    lit1 = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h20000000, 32'h30008001, 32'h00000007,
             32'h20000000, 32'h30008001, 32'h0000000D, 32'h20000000, 32'h20000000};

    repeat (3) @(negedge clk);
    chk("reset_icap_i", icap_i, 32'hFFFFFFFF);
    chk("reset_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // 1: write CMD register
    wlog.delete();
    do_req(2'b00, 5'h04, 32'h00000007, e, rd);
    chk("wr_err", 32'(e), 32'd0);
    chk("wr_word_count", 32'(wlog.size()), 32'd11);
    for (int i = 0; i < 11 && i < wlog.size(); i++) chk($sformatf("wr_word%0d", i), wlog[i], lit1[i]);

    // 2: read STAT register
    wlog.delete(); rd_low = 0;
    do_req(2'b01, 5'h07, 32'd0, e, rd);
    chk("rd_rdata", rd, 32'h12345678);
    chk("rd_err", 32'(e), 32'd0);
    chk("rd_low_cycles", 32'(rd_low), 32'd4);
    chk("rd_word_count", 32'(wlog.size()), 32'd11);
    if (wlog.size() > 4) chk("rd_header", wlog[4], 32'h2800E001);

    // 3: reserved op
    wlog.delete();
    do_req(2'b11, 5'h01, 32'h1, e, rd);
    chk("op11_err", 32'(e), 32'd1);
    chk("op11_no_words", 32'(wlog.size()), 32'd0);

    // 4: reset in RD_WAIT cycle 2, then a normal write
    req_op = 2'b01; req_addr = 5'h07; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rd_cyc == 2) begin found = 1; break; end
    end
    chk("rd_wait_reached", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_csib", 32'(icap_csib), 32'd1);
    chk("rst_rdwrb", 32'(icap_rdwrb), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_no_resp", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    do_req(2'b00, 5'h10, 32'hCAFEF00D, e, rd);
    chk("post_rst_wr_err", 32'(e), 32'd0);

    // 6: req_valid held across three back-to-back writes
    wlog.delete(); n_resp = 0;
    req_op = 2'b00; req_addr = 5'h02; req_wdata = 32'hA5A50001; req_valid = 1'b1;
    repeat (30) @(negedge clk);
    req_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("held_valid_resps", 32'(n_resp), 32'd3);
    chk("held_valid_words", 32'(wlog.size()), 32'd33);

    // 5: IPROG
`ifdef ICAP_IPROG_EN
    wlog.delete(); n_resp = 0;
    req_op = 2'b10; req_wdata = 32'h00400000; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (25) @(negedge clk);
    chk("iprog_words", 32'(wlog.size()), 32'd8);
    if (wlog.size() == 8) begin
      chk("iprog_wbstar_hdr", wlog[3], 32'h30020001);
      chk("iprog_wbstar", wlog[4], 32'h00400000);
      chk("iprog_cmd", wlog[6], 32'h0000000F);
      chk("iprog_last", wlog[7], 32'h20000000);
    end
    chk("iprog_csib", 32'(icap_csib), 32'd1);
    chk("iprog_ready", 32'(req_ready), 32'd0);
    chk("iprog_no_resp", 32'(n_resp), 32'd0);
`else
    do_req(2'b10, 5'h00, 32'h00400000, e, rd);
    chk("op10_err", 32'(e), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/icap_reg_access.md
Name: icap_reg_access

Overview:
- Sequencer that owns the 7-series ICAPE2 port and runs complete configuration-register transactions on request.
- Supported transactions: single-word Type-1 write, single-word Type-1 read.
- Each transaction is wrapped in sync and desync sequences.
- Sits between the control/IPbus register space and the ICAPE2 instance in the top level.
- Performs the ICAP per-byte bit reversal in both directions, so requesters use plain bitstream word values.

Parameters:
- READ_WAIT, 4: cycles CSIB is held low with RDWRB=1 during readback; data is captured in the last of these cycles (legal range 1..15).

Ports:
- clk  in  1  clock; the ICAPE2 CLK pin is driven from this clock, inverted, at the top level.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (IDLE only).
- req_op  in  2  00 = write, 01 = read, 10 = IPROG (see Optional Feature), 11 = reserved.
- req_addr  in  5  configuration register address.
- req_wdata  in  32  write data (write op; WBSTAR value for IPROG).
- resp_valid  out  1  one-cycle pulse: transaction finished.
- resp_rdata  out  32  readback word (bit-swap undone); 0 for writes.
- resp_err  out  1  qualifies resp_valid; 1 = op rejected, nothing sent to ICAP.
- icap_csib  out  1  to ICAPE2 CSIB, active low.
- icap_rdwrb  out  1  to ICAPE2 RDWRB; 0 = write.
- icap_i  out  32  to ICAPE2 I, already bit-swapped.
- icap_o  in  32  from ICAPE2 O, raw.

Behaviour:
- All outputs are registered.
- Reset values:
  - csib = 1, rdwrb = 0, icap_i = 0xFFFFFFFF.
  - req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Bit swap: out bit [8k+j] = value bit [8k+7-j] for each byte k. It is applied to icap_i, and to icap_o before resp_rdata.
- Header words:
  - WR_HDR = 0x30000001 | addr<<13.
  - RD_HDR = 0x28000001 | addr<<13.
  - CMD_HDR = 0x30008001, DESYNC = 0x0000000D.
  - DUMMY = 0xFFFFFFFF, SYNC = 0xAA995566, NOOP = 0x20000000.
- Handshake:
  - A request is accepted on the edge where req_valid and req_ready are both 1; op, addr and wdata are latched.
  - req_ready drops on the next cycle and stays low until the cycle after resp_valid.
- Word issue: the first word appears on icap_i with csib = 0 in the cycle after acceptance. One word is issued per cycle, with no gaps inside a word group.
- Write states:
  - IDLE -> SYNC -> WR_BODY -> DESYNC -> RESP.
  - Words: DUMMY, SYNC, NOOP, NOOP, WR_HDR, wdata, NOOP, CMD_HDR, DESYNC, NOOP, NOOP.
  - That is 11 cycles with csib = 0. The following cycle has csib = 1 and resp_valid = 1.
- Read states:
  - IDLE -> SYNC -> RD_HDR -> TURN_A -> TURN_B -> RD_WAIT -> TURN_C -> TURN_D -> DESYNC -> RESP.
  - Words: DUMMY, SYNC, NOOP, NOOP, RD_HDR, NOOP, NOOP.
  - TURN_A: csib = 1, rdwrb = 0.
  - TURN_B: csib = 1, rdwrb = 1.
  - RD_WAIT: csib = 0, rdwrb = 1 for READ_WAIT cycles; icap_o is captured at the edge ending the last cycle.
  - TURN_C: csib = 1, rdwrb = 1.
  - TURN_D: csib = 1, rdwrb = 0.
  - DESYNC: CMD_HDR, DESYNC, NOOP, NOOP with csib = 0.
  - RESP: csib = 1, resp_valid = 1, resp_rdata = captured word.
- rdwrb changes only while csib = 1.
- A word counter (4 bit) indexes the word within the current group and resets on every state change.
- req_op = 11 is rejected: one cycle later resp_valid = 1 and resp_err = 1; the ICAP pins stay idle.
- Reset mid-operation: on the next edge the block is in IDLE with reset values on all outputs; no desync is sent.
- req_valid while busy is ignored; it is not queued.

Optional Feature:
- Macro: ICAP_IPROG_EN.
- Defined: op 10 issues DUMMY, SYNC, NOOP, 0x30020001 (WBSTAR write), wdata, CMD_HDR, 0x0000000F (IPROG), NOOP with csib = 0.
  - After that the block sets csib = 1 and enters IPROG_DONE.
  - In IPROG_DONE: req_ready = 0, no resp_valid, the block stays until reset.
- Undefined: op 10 is rejected like op 11 (resp_err = 1). The IPROG_DONE state is not present.

Test Plan:
1. Write addr 0x04 (CMD), wdata 0x00000007:
   - icap_i (unswapped) = FFFFFFFF, AA995566, 20000000, 20000000, 30008001, 00000007, 20000000, 30008001, 0000000D, 20000000, 20000000.
   - csib = 0 for exactly those 11 cycles; resp_valid 1 cycle later with err = 0.
2. Read addr 0x07 (STAT), model returns swapped 0x12345678 during RD_WAIT with READ_WAIT = 4:
   - header 0x2800E001.
   - rdwrb rises only while csib = 1.
   - csib low for 4 read cycles.
   - resp_rdata = 0x12345678.
3. req_op = 11:
   - csib stays 1.
   - resp_valid and resp_err both 1, one cycle after acceptance.
   - req_ready back to 1 the next cycle.
4. Reset asserted during read, in RD_WAIT cycle 2:
   - next cycle csib = 1, rdwrb = 0, req_ready = 1, no resp_valid.
   - a following write completes normally.
5. ICAP_IPROG_EN, op 10, wdata 0x00400000:
   - 8-word IPROG stream ending 0000000F, 20000000.
   - then csib = 1, req_ready = 0 indefinitely.
   - without the macro the same request gives resp_err = 1.
6. req_valid held high across a whole write:
   - exactly one transaction per acceptance.
   - the second acceptance occurs the cycle after req_ready returns high.
